pcm_frame_fifo: RTL and testbench

Single-clock, parametrised PCM sample FIFO that sits between the CPU's memory-mapped audio write path and the audio controller's sample read port. Its storage generalises the fixed 20-bit, 8-deep sample FIFO in width, depth and channel count. The CPU writes one sample per cycle; the block packs these round-robin into multi-channel frames and the consumer pops whole frames. Additions over the fixed FIFO: mono-duplicate mode, almost-full threshold, flush, overflow pulse and a saturating underflow counter. On underflow the output holds the last frame.

---
 rtl/pcm_frame_fifo.sv | 166 ++++++++++++++++
 tb/tb_pcm_frame_fifo.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcm_frame_fifo.sv
// pcm_frame_fifo
//
// Single-clock PCM sample FIFO between the CPU audio write path and the
// audio controller's frame read port. The CPU writes one sample per cycle.
// The samples are packed round-robin into CHANNELS-wide frames in a staging
// register. Each completed frame is committed to a DEPTH-entry frame store,
// and the consumer pops whole frames.
//
// Parameters
//   SAMPLE_WIDTH  bits per PCM sample
//   CHANNELS      samples per frame (2 or more)
//   DEPTH         frames of storage (power of 2, 2 or more)
//   AFULL_THRESH  almost_full asserts when count >= this value (1..DEPTH)
//   CNT_WIDTH     width of the saturating underflow counter
//
// Ports
//   clk              system clock, rising edge
//   reset_b          asynchronous active-low reset
//   mono             1 = every accepted write fills all channels of a frame
//   flush            synchronous clear of frame store and staging state
//   wr_en, din       write one sample (two's complement)
//   wr_chan          channel the next stereo/multi write will fill
//   full             count == DEPTH
//   almost_full      count >= AFULL_THRESH
//   overflow         one-cycle pulse after a write was dropped
//   rd_en            pop one frame
//   dout             registered frame, channel k at [k*SAMPLE_WIDTH +: SAMPLE_WIDTH]
//   empty            count == 0
//   count            committed frames held
//   underflow_count  saturating count of pops attempted while empty

module pcm_frame_fifo #(
    parameter int SAMPLE_WIDTH = 20,
    parameter int CHANNELS     = 2,
    parameter int DEPTH        = 8,
    parameter int AFULL_THRESH = 6,
    parameter int CNT_WIDTH    = 16,
    localparam int CHW = ($clog2(CHANNELS) > 1) ? $clog2(CHANNELS) : 1,
    localparam int AW  = $clog2(DEPTH),
    localparam int FW  = CHANNELS * SAMPLE_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset_b,
    input  logic                    mono,
    input  logic                    flush,
    input  logic                    wr_en,
    input  logic [SAMPLE_WIDTH-1:0] din,
    output logic [CHW-1:0]          wr_chan,
    output logic                    full,
    output logic                    almost_full,
    output logic                    overflow,
    input  logic                    rd_en,
    output logic [FW-1:0]           dout,
    output logic                    empty,
    output logic [AW:0]             count,
    output logic [CNT_WIDTH-1:0]    underflow_count
);

    localparam logic [CHW-1:0] LAST_CH = CHW'(CHANNELS - 1);
    localparam logic [AW:0]    DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0]    AFULL_C = (AW + 1)'(AFULL_THRESH);

    logic [FW-1:0]           mem [DEPTH];
    logic [SAMPLE_WIDTH-1:0] stage [CHANNELS];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;

    logic                    accept;
    logic                    drop;
    logic                    commit;
    logic                    pop;
    logic                    under_hit;
    logic [AW:0]             count_nxt;
    logic [CHW-1:0]          wr_chan_nxt;
    logic [FW-1:0]           frame_in;

    always_comb begin
        accept      = wr_en & ~full & ~flush;
        drop        = wr_en & full & ~flush;
        commit      = accept & (mono | (wr_chan == LAST_CH));
        // Pops are qualified by the registered empty flag, so a frame
        // committed this cycle is never bypassed to a simultaneous pop.
        pop         = rd_en & ~empty & ~flush;
        under_hit   = rd_en & empty & ~flush;

        if (flush) begin
            count_nxt = '0;
        end else begin
            count_nxt = count + (AW + 1)'(commit) - (AW + 1)'(pop);
        end

        // Mono forces wr_chan to 0 every cycle, which also discards any
        // partial frame left over when mono is switched on mid-frame.
        wr_chan_nxt = wr_chan;
        if (flush || mono) begin
            wr_chan_nxt = '0;
        end else if (accept) begin
            wr_chan_nxt = commit ? '0 : wr_chan + CHW'(1);
        end

        frame_in = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (mono || (k == CHANNELS - 1)) begin
                frame_in[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = din;
            end else begin
                frame_in[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = stage[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            mem[wr_ptr] <= frame_in;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            wr_chan         <= '0;
            dout            <= '0;
            underflow_count <= '0;
            overflow        <= 1'b0;
            full            <= 1'b0;
            almost_full     <= 1'b0;
            empty           <= 1'b1;
            for (int k = 0; k < CHANNELS; k++) begin
                stage[k] <= '0;
            end
        end else begin
            count       <= count_nxt;
            wr_chan     <= wr_chan_nxt;
            overflow    <= drop;
            // Flags follow the next count so they line up with count itself.
            full        <= (count_nxt == DEPTH_C);
            almost_full <= (count_nxt >= AFULL_C);
            empty       <= (count_nxt == '0);

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                for (int k = 0; k < CHANNELS; k++) begin
                    stage[k] <= '0;
                end
            end else begin
                if (accept && !mono) begin
                    stage[wr_chan] <= din;
                end
                if (commit) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                    dout   <= mem[rd_ptr];
                end
            end

            if (under_hit && (underflow_count != '1)) begin
                underflow_count <= underflow_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_pcm_frame_fifo.sv
// tb_pcm_frame_fifo
//
// Randomised and directed stimulus for pcm_frame_fifo. A queue-based frame
// model tracks expected outputs. Two instances share all inputs: the default
// build, and one with a 2-bit underflow counter for the saturation check.

module tb_pcm_frame_fifo;

    localparam int SW = 20;
    localparam int CH = 2;
    localparam int DP = 8;
    localparam int AT = 6;
    localparam int FW = CH * SW;

    logic          clk = 1'b0;
    logic          reset_b = 1'b0;
    logic          mono = 1'b0;
    logic          flush = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [SW-1:0] din = '0;

    logic          wr_chan, full, almost_full, overflow, empty;
    logic [FW-1:0] dout;
    logic [3:0]    count;
    logic [15:0]   uf;

    logic          c2_wr_chan, c2_full, c2_almost_full, c2_overflow, c2_empty;
    logic [FW-1:0] c2_dout;
    logic [3:0]    c2_count;
    logic [1:0]    c2_uf;

    int n_checks = 0;
    int n_errors = 0;

    logic [FW-1:0] m_q [$];
    logic [SW-1:0] m_stage [CH];
    int            m_chan;
    logic [FW-1:0] m_dout;
    int            m_uf;
    bit            m_ovf;

    pcm_frame_fifo #(
        .SAMPLE_WIDTH(SW), .CHANNELS(CH), .DEPTH(DP),
        .AFULL_THRESH(AT), .CNT_WIDTH(16)
    ) u_dut (
        .clk(clk), .reset_b(reset_b), .mono(mono), .flush(flush),
        .wr_en(wr_en), .din(din), .wr_chan(wr_chan), .full(full),
        .almost_full(almost_full), .overflow(overflow), .rd_en(rd_en),
        .dout(dout), .empty(empty), .count(count), .underflow_count(uf)
    );

    pcm_frame_fifo #(
        .SAMPLE_WIDTH(SW), .CHANNELS(CH), .DEPTH(DP),
        .AFULL_THRESH(AT), .CNT_WIDTH(2)
    ) u_dut_c2 (
        .clk(clk), .reset_b(reset_b), .mono(mono), .flush(flush),
        .wr_en(wr_en), .din(din), .wr_chan(c2_wr_chan), .full(c2_full),
        .almost_full(c2_almost_full), .overflow(c2_overflow), .rd_en(rd_en),
        .dout(c2_dout), .empty(c2_empty), .count(c2_count),
        .underflow_count(c2_uf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        for (int k = 0; k < CH; k++) m_stage[k] = '0;
        m_chan = 0;
        m_dout = '0;
        m_uf   = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_step();
        int            n;
        logic [FW-1:0] f;
        n = m_q.size();
        if (flush) begin
            m_q.delete();
            for (int k = 0; k < CH; k++) m_stage[k] = '0;
            m_chan = 0;
            m_ovf  = 1'b0;
            return;
        end
        m_ovf = wr_en && (n == DP);
        if (rd_en) begin
            if (n == 0) m_uf++;
            else        m_dout = m_q.pop_front();
        end
        if (mono) begin
            m_chan = 0;
            if (wr_en && n != DP) m_q.push_back({CH{din}});
        end else if (wr_en && n != DP) begin
            m_stage[m_chan] = din;
            if (m_chan == CH - 1) begin
                f = '0;
                for (int k = 0; k < CH; k++) f[k*SW +: SW] = m_stage[k];
                m_q.push_back(f);
                m_chan = 0;
            end else begin
                m_chan++;
            end
        end
    endtask

    task automatic compare_all();
        int n;
        n = m_q.size();
        chk("count",       count,       n);
        chk("empty",       empty,       n == 0);
        chk("full",        full,        n == DP);
        chk("almost_full", almost_full, n >= AT);
        chk("overflow",    overflow,    m_ovf);
        chk("wr_chan",     wr_chan,     m_chan);
        chk("dout",        dout,        m_dout);
        chk("underflow",   uf,          (m_uf > 65535) ? 65535 : m_uf);
        chk("c2_underflow", c2_uf,      (m_uf > 3) ? 3 : m_uf);
        chk("c2_count",    c2_count,    n);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #22;
        compare_all();
        reset_b = 1'b1;

        // ramp -50..50, popping whenever frames are held
        for (int v = -50; v <= 50; v++) begin
            wr_en = 1'b1;
            din   = SW'(v);
            rd_en = (m_q.size() != 0);
            tick();
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("ramp_last_frame", dout, {SW'(49), SW'(48)});
        chk("ramp_wr_chan", wr_chan, 1);
        chk("ramp_count", count, 0);

        flush = 1'b1;
        tick();
        flush = 1'b0;

        // fill to full, then overflow
        for (int i = 0; i < 2 * DP; i++) begin
            wr_en = 1'b1;
            din   = SW'($urandom_range(200, 1200));
            tick();
        end
        wr_en = 1'b0;
        chk("fill_full", full, 1);
        chk("fill_afull", almost_full, 1);
        wr_en = 1'b1;
        din   = SW'(99);
        tick();
        wr_en = 1'b0;
        chk("ovf_pulse", overflow, 1);
        chk("ovf_count", count, DP);
        tick();
        chk("ovf_clear", overflow, 0);
        rd_en = 1'b1;
        repeat (DP) tick();
        rd_en = 1'b0;

        // underflow holds dout; saturation on the 2-bit counter
        wr_en = 1'b1;
        din = SW'(7); tick();
        din = SW'(8); tick();
        wr_en = 1'b0;
        rd_en = 1'b1;
        tick();
        repeat (3) tick();
        rd_en = 1'b0;
        chk("uf_hold_dout", dout, {SW'(8), SW'(7)});
        chk("uf_count3", uf, 3);
        rd_en = 1'b1;
        repeat (2) tick();
        rd_en = 1'b0;
        chk("uf_count5", uf, 5);
        chk("uf_sat_c2", c2_uf, 3);

        // mono duplicate and mono toggle discarding a partial frame
        mono = 1'b1; wr_en = 1'b1; din = SW'(5);
        tick();
        wr_en = 1'b0;
        chk("mono_count", count, 1);
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        chk("mono_dout", dout, {SW'(5), SW'(5)});
        mono = 1'b0; wr_en = 1'b1; din = SW'(1);
        tick();
        wr_en = 1'b0;
        chk("toggle_chan1", wr_chan, 1);
        mono = 1'b1; tick(); mono = 1'b0;
        chk("toggle_chan0", wr_chan, 0);
        wr_en = 1'b1;
        din = SW'(2); tick();
        din = SW'(3); tick();
        wr_en = 1'b0;
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        chk("toggle_frame", dout, {SW'(3), SW'(2)});

        // commit and pop together at count 4, across pointer wraps
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; din = SW'($urandom); tick();
        end
        for (int f = 0; f < 3 * DP; f++) begin
            wr_en = 1'b1; rd_en = 1'b0; din = SW'($urandom); tick();
            rd_en = 1'b1; din = SW'($urandom); tick();
            chk("simul_count", count, 4);
        end
        wr_en = 1'b0;
        rd_en = 1'b1;
        repeat (4) tick();
        rd_en = 1'b0;

        // random traffic
        repeat (400) begin
            wr_en = ($urandom_range(0, 9) < 7);
            rd_en = $urandom_range(0, 1);
            if ($urandom_range(0, 19) == 0) mono = ~mono;
            flush = ($urandom_range(0, 49) == 0);
            din   = SW'($urandom);
            tick();
        end
        wr_en = 1'b0; rd_en = 1'b0; mono = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;

        // flush mid-frame at count 5
        wr_en = 1'b1;
        din = SW'(11); tick();
        din = SW'(12); tick();
        wr_en = 1'b0;
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        for (int i = 0; i < 11; i++) begin
            wr_en = 1'b1; din = SW'(300 + i); tick();
        end
        chk("pre_flush_count", count, 5);
        flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1; din = SW'(77);
        tick();
        flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        chk("flush_count", count, 0);
        chk("flush_empty", empty, 1);
        chk("flush_wr_chan", wr_chan, 0);
        chk("flush_dout", dout, {SW'(12), SW'(11)});

        // asynchronous reset mid-write
        wr_en = 1'b1; din = SW'(33);
        tick();
        #2 reset_b = 1'b0;
        #1;
        chk("arst_dout", dout, 0);
        chk("arst_wr_chan", wr_chan, 0);
        chk("arst_count", count, 0);
        model_reset();
        #2 reset_b = 1'b1;
        wr_en = 1'b0;
        tick();
        wr_en = 1'b1;
        din = SW'(21); tick();
        din = SW'(22); tick();
        wr_en = 1'b0;
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        chk("post_reset_frame", dout, {SW'(22), SW'(21)});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
